// File: rtl/stopwatch_controller.sv
// Stopwatch control FSM: start/stop, lap freeze, long-press clear and pause blink.
// Drives the counter enable/clear and the digit mux/blank for the segment driver.
module stopwatch_controller #(
    parameter int LONG_PRESS_TICKS = 200,
    parameter int BLINK_TICKS      = 50
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        tick,
    input  logic        start_stop_pressed,
    input  logic        lap_reset_pressed,
    input  logic        lap_reset_level,
    input  logic [15:0] live_digits,
    output logic        counter_enable,
    output logic        counter_reset,
    output logic [15:0] disp_digits,
    output logic [3:0]  disp_blank,
    output logic [1:0]  state_out
);

    localparam int LPW = $clog2(LONG_PRESS_TICKS + 1);
    localparam int BW  = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [LPW-1:0] LP_MAX  = LPW'(LONG_PRESS_TICKS);
    localparam logic [BW-1:0]  BL_LAST = BW'(BLINK_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2,
        LAP     = 2'd3
    } state_t;

    state_t         state, state_nxt;
    logic [15:0]    lap_reg;
    logic [LPW-1:0] lp_cnt, lp_nxt;
    logic           long_fired, fire;
    logic [BW-1:0]  blink_cnt, blink_nxt;
    logic           phase, phase_nxt;
    logic           clear_req, lap_load, lap_clear;

    always_comb begin
        lp_nxt = lp_cnt;
        if (!lap_reset_level)
            lp_nxt = '0;
        else if (tick && lp_cnt != LP_MAX)
            lp_nxt = lp_cnt + 1'b1;
        // counter saturates, so long_fired keeps a held key from re-firing
        fire = lap_reset_level && tick && !long_fired && (lp_nxt == LP_MAX);
    end

    always_comb begin
        state_nxt = state;
        clear_req = 1'b0;
        lap_load  = 1'b0;
        lap_clear = 1'b0;
        if (fire) begin
            state_nxt = IDLE;
            clear_req = 1'b1;
            lap_clear = 1'b1;
        end else if (start_stop_pressed) begin
            unique case (state)
                IDLE:    state_nxt = RUNNING;
                RUNNING: state_nxt = PAUSED;
                PAUSED:  state_nxt = RUNNING;
                LAP:     state_nxt = PAUSED;
            endcase
        end else if (lap_reset_pressed) begin
            unique case (state)
                IDLE: clear_req = 1'b1;
                RUNNING: begin
                    state_nxt = LAP;
                    lap_load  = 1'b1;
                end
                LAP: state_nxt = RUNNING;
                PAUSED: begin
                    state_nxt = IDLE;
                    clear_req = 1'b1;
                    lap_clear = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        blink_nxt = '0;
        phase_nxt = 1'b0;
        // only a stay in PAUSED keeps the blink running; entry restarts it
        if (state == PAUSED && state_nxt == PAUSED) begin
            blink_nxt = blink_cnt;
            phase_nxt = phase;
            if (tick) begin
                if (blink_cnt == BL_LAST) begin
                    blink_nxt = '0;
                    phase_nxt = ~phase;
                end else begin
                    blink_nxt = blink_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            lap_reg        <= '0;
            lp_cnt         <= '0;
            long_fired     <= 1'b0;
            blink_cnt      <= '0;
            phase          <= 1'b0;
            counter_enable <= 1'b0;
            counter_reset  <= 1'b0;
            disp_blank     <= '0;
        end else begin
            state          <= state_nxt;
            lp_cnt         <= lp_nxt;
            long_fired     <= lap_reset_level && (long_fired || fire);
            blink_cnt      <= blink_nxt;
            phase          <= phase_nxt;
            counter_reset  <= clear_req;
            counter_enable <= (state_nxt == RUNNING) || (state_nxt == LAP);
            disp_blank     <= {4{phase_nxt}};
            if (lap_clear)
                lap_reg <= '0;
            else if (lap_load)
                lap_reg <= live_digits;
        end
    end

    assign state_out   = state;
    assign disp_digits = (state == LAP) ? lap_reg : live_digits;

endmodule

// File: tb/tb_stopwatch_controller.sv
// Random and directed stimulus for stopwatch_controller against an
// event-level reference model (tick counts since hold / since pause).
module tb_stopwatch_controller;

    localparam int LONG  = 200;
    localparam int BLINK = 50;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        tick = 1'b0;
    logic        start_stop_pressed = 1'b0;
    logic        lap_reset_pressed = 1'b0;
    logic        lap_reset_level = 1'b0;
    logic [15:0] live_digits = '0;
    logic        counter_enable;
    logic        counter_reset;
    logic [15:0] disp_digits;
    logic [3:0]  disp_blank;
    logic [1:0]  state_out;

    int checks = 0;
    int failures = 0;

    int          m_state;
    logic [15:0] m_lap;
    int          m_held;
    int          m_pticks;
    logic        m_creset;

    stopwatch_controller #(
        .LONG_PRESS_TICKS(LONG),
        .BLINK_TICKS(BLINK)
    ) dut (
        .clock(clock),
        .reset(reset),
        .tick(tick),
        .start_stop_pressed(start_stop_pressed),
        .lap_reset_pressed(lap_reset_pressed),
        .lap_reset_level(lap_reset_level),
        .live_digits(live_digits),
        .counter_enable(counter_enable),
        .counter_reset(counter_reset),
        .disp_digits(disp_digits),
        .disp_blank(disp_blank),
        .state_out(state_out)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state  = 0;
        m_lap    = '0;
        m_held   = 0;
        m_pticks = 0;
        m_creset = 1'b0;
    endtask

    // 0=IDLE 1=RUNNING 2=PAUSED 3=LAP
    task automatic model_step(input logic s, input logic l, input logic lvl,
                              input logic t, input logic [15:0] live);
        int  prev;
        logic fire;
        prev = m_state;
        if (!lvl) m_held = 0;
        else if (t) m_held++;
        fire = lvl && t && (m_held == LONG);
        m_creset = 1'b0;
        if (fire) begin
            m_state = 0;
            m_lap = '0;
            m_creset = 1'b1;
        end else if (s) begin
            m_state = (m_state == 0 || m_state == 2) ? 1 : 2;
        end else if (l) begin
            case (m_state)
                0: m_creset = 1'b1;
                1: begin m_state = 3; m_lap = live; end
                3: m_state = 1;
                default: begin m_state = 0; m_lap = '0; m_creset = 1'b1; end
            endcase
        end
        if (m_state == 2 && prev == 2) begin
            if (t) m_pticks++;
        end else begin
            m_pticks = 0;
        end
    endtask

    task automatic check_outputs(input string w);
        logic [3:0]  eb;
        logic [15:0] ed;
        eb = (m_state == 2 && ((m_pticks / BLINK) % 2 == 1)) ? 4'hF : 4'h0;
        ed = (m_state == 3) ? m_lap : live_digits;
        chk({w, "_state"}, 32'(state_out), 32'(m_state));
        chk({w, "_en"}, 32'(counter_enable), 32'(m_state == 1 || m_state == 3));
        chk({w, "_clr"}, 32'(counter_reset), 32'(m_creset));
        chk({w, "_blank"}, 32'(disp_blank), 32'(eb));
        chk({w, "_digits"}, 32'(disp_digits), 32'(ed));
    endtask

    task automatic step(input string w, input logic s, input logic l,
                        input logic lvl, input logic t, input logic [15:0] live);
        @(negedge clock);
        start_stop_pressed = s;
        lap_reset_pressed  = l;
        lap_reset_level    = lvl;
        tick               = t;
        live_digits        = live;
        model_step(s, l, lvl, t, live);
        @(posedge clock);
        #1;
        check_outputs(w);
    endtask

    task automatic check_reset_values(input string w);
        chk({w, "_state"}, 32'(state_out), 32'd0);
        chk({w, "_en"}, 32'(counter_enable), 32'd0);
        chk({w, "_clr"}, 32'(counter_reset), 32'd0);
        chk({w, "_blank"}, 32'(disp_blank), 32'd0);
        chk({w, "_digits"}, 32'(disp_digits), 32'(live_digits));
    endtask

    initial begin
        int pulses;
        model_reset();
        live_digits = 16'h0042;
        repeat (2) @(negedge clock);
        check_reset_values("rst");
        reset = 1'b0;

        // T1
        step("t1a", 1, 0, 0, 0, 16'h0000);
        chk("t1_en", 32'(counter_enable), 32'd1);
        step("t1b", 1, 0, 0, 0, 16'h0000);
        chk("t1_pause", 32'(state_out), 32'd2);

        // T2
        step("t2a", 1, 0, 0, 0, 16'h1234);
        step("t2b", 0, 1, 0, 0, 16'h1234);
        step("t2c", 0, 0, 0, 0, 16'h1250);
        chk("t2_frozen", 32'(disp_digits), 32'h1234);
        step("t2d", 0, 1, 0, 0, 16'h1250);
        chk("t2_live", 32'(disp_digits), 32'h1250);

        // T3
        step("t3a", 1, 0, 0, 0, 16'h0100);
        for (int i = 1; i <= 100; i++) begin
            step("t3t", 0, 0, 0, 1, 16'h0100);
            chk("t3_blink", 32'(disp_blank),
                (i >= 50 && i < 100) ? 32'hF : 32'h0);
        end
        step("t3b", 1, 0, 0, 0, 16'h0100);
        chk("t3_unblank", 32'(disp_blank), 32'd0);

        // T4
        pulses = 0;
        for (int i = 1; i <= 500; i++) begin
            step("t4", 0, 0, 1, 1, 16'h0200);
            if (counter_reset) pulses++;
            if (i == 200) chk("t4_idle", 32'(state_out), 32'd0);
        end
        chk("t4_pulses", 32'(pulses), 32'd1);
        step("t4r", 0, 0, 0, 0, 16'h0200);

        // T5
        step("t5a", 1, 0, 0, 0, 16'h0300);
        step("t5b", 0, 1, 0, 0, 16'hABCD);
        step("t5c", 0, 1, 0, 0, 16'h0301);
        step("t5d", 1, 1, 0, 0, 16'h0302);
        chk("t5_prio", 32'(state_out), 32'd2);
        step("t5e", 0, 1, 0, 0, 16'h0303);
        step("t5f", 0, 1, 0, 0, 16'h0000);
        chk("t5_idle_clr", 32'(counter_reset), 32'd1);
        step("t5g", 0, 0, 0, 0, 16'h0000);
        chk("t5_clr_end", 32'(counter_reset), 32'd0);

        // T6
        step("t6a", 1, 0, 0, 0, 16'h0400);
        step("t6b", 0, 1, 0, 0, 16'h0455);
        for (int i = 0; i < 60; i++)
            step("t6h", 0, 0, 1, 1, 16'h0460);
        @(negedge clock);
        start_stop_pressed = 0;
        lap_reset_pressed  = 0;
        tick               = 0;
        #2 reset = 1'b1;
        #1;
        check_reset_values("t6");
        model_reset();
        lap_reset_level = 1'b0;
        @(negedge clock);
        reset = 1'b0;

        // random
        for (int seg = 0; seg < 30; seg++) begin
            int   len;
            logic lvl;
            len = $urandom_range(1, 900);
            lvl = 1'($urandom_range(0, 1));
            for (int i = 0; i < len; i++) begin
                step("rnd",
                     1'($urandom_range(0, 39) == 0),
                     1'($urandom_range(0, 29) == 0),
                     lvl,
                     1'($urandom_range(0, 2) == 0),
                     16'($urandom));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
